// File: rtl/bexkat1_intunit_seq_pkg.sv
// Shared bexkat1 definitions: integer-unit opcodes, integer-unit FSM states,
// and helpers that classify opcodes.
package bexkat1Def;

    typedef enum bit [3:0] {
        INT_MUL, INT_DIV, INT_MOD, INT_MULU, INT_DIVU, INT_MODU,
        INT_MULX, INT_MULUX, INT_EXT, INT_EXTB, INT_COM, INT_NEG
    } intfunc_t;

    typedef enum bit [1:0] {IU_IDLE, IU_PREP, IU_ITER, IU_FIX} intu_state_t;

    // Any opcode above this one is an illegal code.
    localparam intfunc_t INTFUNC_LAST = INT_NEG;

    function automatic logic is_iter_op(input logic [3:0] f);
        return f <= INT_MULUX;
    endfunction

    function automatic logic is_div_op(input logic [3:0] f);
        return (f == INT_DIV) || (f == INT_MOD) || (f == INT_DIVU) || (f == INT_MODU);
    endfunction

    function automatic logic is_signed_op(input logic [3:0] f);
        return (f == INT_MUL) || (f == INT_MULX) || (f == INT_DIV) || (f == INT_MOD);
    endfunction

endpackage

// File: rtl/bexkat1_intunit_seq_intstep.sv
// Combinational UNROLL-deep chain of shift-add multiply or restoring-divide
// steps on the {acc, q} register pair.
module bexkat1_intstep #(
    parameter int WIDTH  = 32,
    parameter int UNROLL = 1
) (
    input  logic             div_i,
    input  logic [WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] m_i,
    output logic [WIDTH-1:0] acc_o,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] acc_s [0:UNROLL];
    logic [WIDTH-1:0] q_s   [0:UNROLL];

    assign acc_s[0] = acc_i;
    assign q_s[0]   = q_i;

    genvar gi;
    generate
        for (gi = 0; gi < UNROLL; gi++) begin : g_step
            logic [WIDTH:0]   sum;
            logic [WIDTH:0]   sel;
            logic [WIDTH:0]   sh;
            logic             fits;
            logic [WIDTH-1:0] acc_n;
            logic [WIDTH-1:0] q_n;

            always_comb begin
                // Multiply: add multiplicand when the multiplier LSB is set, then shift right.
                sum  = {1'b0, acc_s[gi]} + {1'b0, m_i};
                sel  = q_s[gi][0] ? sum : {1'b0, acc_s[gi]};
                // Divide: shift next dividend bit into the partial remainder and trial-subtract.
                sh   = {acc_s[gi], q_s[gi][WIDTH-1]};
                fits = (sh >= {1'b0, m_i});
                if (div_i) begin
                    acc_n = fits ? (sh[WIDTH-1:0] - m_i) : sh[WIDTH-1:0];
                    q_n   = {q_s[gi][WIDTH-2:0], fits};
                end else begin
                    acc_n = sel[WIDTH:1];
                    q_n   = {sel[0], q_s[gi][WIDTH-1:1]};
                end
            end

            assign acc_s[gi+1] = acc_n;
            assign q_s[gi+1]   = q_n;
        end
    endgenerate

    assign acc_o = acc_s[UNROLL];
    assign q_o   = q_s[UNROLL];

endmodule

// File: rtl/bexkat1_intunit_seq.sv
// Multi-cycle bexkat1 integer unit: iterative multiply/divide on magnitudes
// with a final sign fixup, plus single-cycle extend/complement/negate.
module bexkat1_intunit_seq
    import bexkat1Def::*;
#(
    parameter int WIDTH  = 32,
    parameter int UNROLL = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             flush_i,
    input  logic [3:0]       func_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] result_o,
    output logic             divzero_o,
    output logic             illegal_o
);

    localparam int N  = WIDTH / UNROLL;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    intu_state_t      state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [3:0]       func_q, func_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, m_q, m_d;
    logic [WIDTH-1:0] acc_q, acc_d, qr_q, qr_d;
    logic             res_neg_q, res_neg_d, divzero_q, divzero_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             valid_q, valid_d, dz_out_q, dz_out_d, illegal_q, illegal_d;

    logic [WIDTH-1:0] step_acc, step_q;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag, quo_s, rem_s;
    logic [2*WIDTH-1:0] prod_s;

    bexkat1_intstep #(.WIDTH(WIDTH), .UNROLL(UNROLL)) u_step (
        .div_i (is_div_op(func_q)),
        .acc_i (acc_q),
        .q_i   (qr_q),
        .m_i   (m_q),
        .acc_o (step_acc),
        .q_o   (step_q)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        func_d    = func_q;
        a_d       = a_q;
        b_d       = b_q;
        m_d       = m_q;
        acc_d     = acc_q;
        qr_d      = qr_q;
        res_neg_d = res_neg_q;
        divzero_d = divzero_q;
        result_d  = result_q;
        valid_d   = 1'b0;
        dz_out_d  = 1'b0;
        illegal_d = 1'b0;

        a_neg  = a_q[WIDTH-1] & is_signed_op(func_q);
        b_neg  = b_q[WIDTH-1] & is_signed_op(func_q);
        a_mag  = a_neg ? ('0 - a_q) : a_q;
        b_mag  = b_neg ? ('0 - b_q) : b_q;
        prod_s = res_neg_q ? ('0 - {acc_q, qr_q}) : {acc_q, qr_q};
        quo_s  = res_neg_q ? ('0 - qr_q) : qr_q;
        rem_s  = res_neg_q ? ('0 - acc_q) : acc_q;

        case (state_q)
            IU_IDLE: begin
                if (start_i) begin
                    if (is_iter_op(func_i)) begin
                        func_d  = func_i;
                        a_d     = a_i;
                        b_d     = b_i;
                        state_d = IU_PREP;
                    end else begin
                        case (func_i)
                            INT_EXT:  result_d = {{(WIDTH-16){a_i[15]}}, a_i[15:0]};
                            INT_EXTB: result_d = {{(WIDTH-8){a_i[7]}}, a_i[7:0]};
                            INT_COM:  result_d = ~a_i;
                            INT_NEG:  result_d = '0 - a_i;
                            default:  result_d = '0;
                        endcase
                        valid_d   = 1'b1;
                        illegal_d = (func_i > INTFUNC_LAST);
                    end
                end
            end
            IU_PREP: begin
                // Divide keeps the dividend in q and the divisor in m; multiply the reverse.
                m_d       = is_div_op(func_q) ? b_mag : a_mag;
                qr_d      = is_div_op(func_q) ? a_mag : b_mag;
                acc_d     = '0;
                cnt_d     = CW'(N - 1);
                res_neg_d = (func_q == INT_MOD) ? a_neg : (a_neg ^ b_neg);
                divzero_d = is_div_op(func_q) && (b_q == '0);
                state_d   = IU_ITER;
            end
            IU_ITER: begin
                acc_d = step_acc;
                qr_d  = step_q;
                if (cnt_q == '0) state_d = IU_FIX;
                else             cnt_d   = cnt_q - CW'(1);
            end
            IU_FIX: begin
                case (func_q)
                    INT_MUL, INT_MULU:   result_d = prod_s[WIDTH-1:0];
                    INT_MULX, INT_MULUX: result_d = prod_s[2*WIDTH-1:WIDTH];
                    INT_DIV, INT_DIVU:   result_d = divzero_q ? '1 : quo_s;
                    default:             result_d = divzero_q ? a_q : rem_s;
                endcase
                valid_d  = 1'b1;
                dz_out_d = divzero_q;
                state_d  = IU_IDLE;
            end
            default: state_d = IU_IDLE;
        endcase

        // Flush overrides everything, including a same-cycle start.
        if (flush_i) begin
            state_d   = IU_IDLE;
            result_d  = result_q;
            valid_d   = 1'b0;
            dz_out_d  = 1'b0;
            illegal_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IU_IDLE;
            cnt_q     <= '0;
            func_q    <= '0;
            a_q       <= '0;
            b_q       <= '0;
            m_q       <= '0;
            acc_q     <= '0;
            qr_q      <= '0;
            res_neg_q <= 1'b0;
            divzero_q <= 1'b0;
            result_q  <= '0;
            valid_q   <= 1'b0;
            dz_out_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            func_q    <= func_d;
            a_q       <= a_d;
            b_q       <= b_d;
            m_q       <= m_d;
            acc_q     <= acc_d;
            qr_q      <= qr_d;
            res_neg_q <= res_neg_d;
            divzero_q <= divzero_d;
            result_q  <= result_d;
            valid_q   <= valid_d;
            dz_out_q  <= dz_out_d;
            illegal_q <= illegal_d;
        end
    end

    assign busy_o    = (state_q != IU_IDLE);
    assign valid_o   = valid_q;
    assign result_o  = result_q;
    assign divzero_o = dz_out_q;
    assign illegal_o = illegal_q;

endmodule

// File: tb/tb_bexkat1_intunit_seq.sv
// Directed bench for bexkat1_intunit_seq: a UNROLL=1 and a UNROLL=4 instance,
// hand-computed results, latencies and handshake corner cases.
module tb_bexkat1_intunit_seq;
    import bexkat1Def::*;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0, start4 = 1'b0, flush_i = 1'b0;
    logic [3:0]  func_i = '0;
    logic [31:0] a_i = '0, b_i = '0;

    logic        busy1, valid1, dz1, il1;
    logic [31:0] res1;
    logic        busy4, valid4, dz4, il4;
    logic [31:0] res4;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bexkat1_intunit_seq #(.WIDTH(32), .UNROLL(1)) dut1 (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .flush_i(flush_i),
        .func_i(func_i), .a_i(a_i), .b_i(b_i), .busy_o(busy1), .valid_o(valid1),
        .result_o(res1), .divzero_o(dz1), .illegal_o(il1)
    );

    bexkat1_intunit_seq #(.WIDTH(32), .UNROLL(4)) dut4 (
        .clk_i(clk), .rst_i(rst_i), .start_i(start4), .flush_i(flush_i),
        .func_i(func_i), .a_i(a_i), .b_i(b_i), .busy_o(busy4), .valid_o(valid4),
        .result_o(res4), .divzero_o(dz4), .illegal_o(il4)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called just after the accepting edge; returns at the negedge of the valid cycle.
    task automatic wait_valid(input bit use4, output logic [31:0] res, output logic dz,
                              output logic il, output int lat, output int busy_bad);
        lat = -1; busy_bad = 0; res = '0; dz = 1'b0; il = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (use4 ? valid4 : valid1) begin
                res = use4 ? res4 : res1;
                dz  = use4 ? dz4 : dz1;
                il  = use4 ? il4 : il1;
                lat = k;
                if (use4 ? busy4 : busy1) busy_bad++;
                break;
            end else if (!(use4 ? busy4 : busy1)) begin
                busy_bad++;
            end
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the valid cycle.
    task automatic do_op(input string tag, input bit use4, input logic [3:0] f,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_res,
                         input logic exp_dz, input logic exp_il, input int exp_lat);
        logic [31:0] res;
        logic        dz, il;
        int          lat, busy_bad;
        func_i = f; a_i = a; b_i = b;
        if (use4) start4 = 1'b1; else start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0; start4 = 1'b0;
        a_i = $urandom; b_i = $urandom;
        wait_valid(use4, res, dz, il, lat, busy_bad);
        $display("op %-10s u%0d func=%0d a=%h b=%h -> res=%h dz=%b il=%b lat=%0d",
                 tag, use4 ? 4 : 1, f, a, b, res, dz, il, lat);
        check_eq({tag, "_res"}, res, exp_res);
        check_eq({tag, "_dz"}, 32'(dz), 32'(exp_dz));
        check_eq({tag, "_il"}, 32'(il), 32'(exp_il));
        check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check_eq({tag, "_busy"}, 32'(busy_bad), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] r;
        logic        dz, il;
        int          lat, bb, nv, busy11;

        // Reset state
        @(negedge clk);
        check_eq("rst_out1", {res1[31:4], busy1, valid1, dz1, il1}, 32'd0);
        check_eq("rst_out4", {res4[31:4], busy4, valid4, dz4, il4}, 32'd0);
        @(posedge clk); #1;
        rst_i = 1'b0;
        @(posedge clk); #1;

        // Multiply
        do_op("mul",    0, INT_MUL,   32'hFFFFFFF9, 32'd6,        32'hFFFFFFD6, 0, 0, 35);
        do_op("mulux",  0, INT_MULUX, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, 0, 35);
        do_op("mulx",   0, INT_MULX,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 0, 0, 35);
        do_op("mulu",   0, INT_MULU,  32'h00010000, 32'h00010000, 32'h00000000, 0, 0, 35);
        do_op("mul_nn", 0, INT_MUL,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 0, 0, 35);
        // Divide
        do_op("div",    0, INT_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 0, 0, 35);
        do_op("mod",    0, INT_MOD,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 0, 0, 35);
        do_op("div_ov", 0, INT_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, 0, 35);
        do_op("mod_ov", 0, INT_MOD,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 0, 0, 35);
        do_op("divu",   0, INT_DIVU,  32'd100,      32'd7,        32'd14,       0, 0, 35);
        do_op("modu",   0, INT_MODU,  32'd100,      32'd7,        32'd2,        0, 0, 35);
        // Divide by zero
        do_op("divu_z", 0, INT_DIVU,  32'd100,      32'd0,        32'hFFFFFFFF, 1, 0, 35);
        do_op("modu_z", 0, INT_MODU,  32'd100,      32'd0,        32'd100,      1, 0, 35);
        do_op("div_z",  0, INT_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 1, 0, 35);
        do_op("mod_z",  0, INT_MOD,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 1, 0, 35);
        // UNROLL=4
        do_op("divu_z4", 1, INT_DIVU, 32'd100,      32'd0,        32'hFFFFFFFF, 1, 0, 11);
        do_op("modu_z4", 1, INT_MODU, 32'd100,      32'd0,        32'd100,      1, 0, 11);
        do_op("mul4",    1, INT_MUL,  32'hFFFFFFF9, 32'd6,        32'hFFFFFFD6, 0, 0, 11);
        do_op("div4",    1, INT_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 0, 0, 11);
        // Unary and illegal
        do_op("extb",   0, INT_EXTB,  32'h00000080, 32'd0, 32'hFFFFFF80, 0, 0, 1);
        do_op("ext",    0, INT_EXT,   32'h00018000, 32'd0, 32'hFFFF8000, 0, 0, 1);
        do_op("com",    0, INT_COM,   32'h0F0F0F0F, 32'd0, 32'hF0F0F0F0, 0, 0, 1);
        do_op("neg",    0, INT_NEG,   32'h00000001, 32'd0, 32'hFFFFFFFF, 0, 0, 1);
        do_op("neg_mn", 0, INT_NEG,   32'h80000000, 32'd0, 32'h80000000, 0, 0, 1);
        do_op("ill12",  0, 4'd12,     32'h12345678, 32'd9, 32'h00000000, 0, 1, 1);
        do_op("ill15",  0, 4'd15,     32'h12345678, 32'd9, 32'h00000000, 0, 1, 1);

        // Start while busy is ignored
        func_i = INT_MUL; a_i = 32'd3; b_i = 32'd5; start_i = 1'b1;
        @(posedge clk); #1;
        nv = 0; lat = -1; r = '0;
        for (int k = 1; k <= 45; k++) begin
            if (k == 5) begin func_i = INT_MUL; a_i = 32'd7; b_i = 32'd7; start_i = 1'b1; end
            else start_i = 1'b0;
            @(negedge clk);
            if (valid1) begin nv++; if (lat < 0) begin lat = k; r = res1; end end
            @(posedge clk); #1;
        end
        $display("op busy_start  res=%h lat=%0d valids=%0d", r, lat, nv);
        check_eq("ign_res", r, 32'd15);
        check_eq("ign_lat", 32'(lat), 32'd35);
        check_eq("ign_nv", 32'(nv), 32'd1);

        // Flush in cycle 10
        func_i = INT_DIVU; a_i = 32'd1000; b_i = 32'd3; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        nv = 0; busy11 = -1;
        for (int k = 1; k <= 45; k++) begin
            flush_i = (k == 10);
            @(negedge clk);
            if (valid1) nv++;
            if (k == 11) busy11 = int'(busy1);
            @(posedge clk); #1;
        end
        flush_i = 1'b0;
        $display("op flush      busy11=%0d valids=%0d", busy11, nv);
        check_eq("flush_busy", 32'(busy11), 32'd0);
        check_eq("flush_nv", 32'(nv), 32'd0);

        // Flush together with a unary start from idle: start dropped
        func_i = INT_NEG; a_i = 32'd5; start_i = 1'b1; flush_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0; flush_i = 1'b0;
        @(negedge clk);
        $display("op flush_start valid=%b busy=%b", valid1, busy1);
        check_eq("fls_st_valid", {busy1, valid1}, 32'd0);
        @(posedge clk); #1;

        // Back-to-back: second start issued in the first op's valid cycle
        func_i = INT_DIVU; a_i = 32'd100; b_i = 32'd7; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        wait_valid(0, r, dz, il, lat, bb);
        func_i = INT_MULU; a_i = 32'd7; b_i = 32'd6; start_i = 1'b1;
        $display("op b2b_first   res=%h lat=%0d", r, lat);
        check_eq("b2b_a_res", r, 32'd14);
        check_eq("b2b_a_lat", 32'(lat), 32'd35);
        @(posedge clk); #1;
        start_i = 1'b0;
        wait_valid(0, r, dz, il, lat, bb);
        $display("op b2b_second  res=%h lat=%0d", r, lat);
        check_eq("b2b_b_res", r, 32'd42);
        check_eq("b2b_b_lat", 32'(lat), 32'd35);
        @(posedge clk); #1;

        // Reset in cycle 20 of a DIV
        func_i = INT_DIV; a_i = 32'd1000; b_i = 32'd7; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (19) begin @(posedge clk); #1; end
        @(negedge clk);
        rst_i = 1'b1;
        #1;
        $display("op reset_mid  busy=%b valid=%b res=%h dz=%b il=%b", busy1, valid1, res1, dz1, il1);
        check_eq("rstmid_res", res1, 32'd0);
        check_eq("rstmid_flags", {busy1, valid1, dz1, il1}, 32'd0);
        @(posedge clk); #1;
        rst_i = 1'b0;
        nv = 0;
        for (int k = 0; k < 45; k++) begin
            @(negedge clk);
            if (valid1) nv++;
        end
        check_eq("rstmid_nv", 32'(nv), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
